pack_adapter: RTL and testbench

PACK_ADAPTER -- requirements
Module: pack_adapter

---
 rtl/pack_adapter.sv | 199 +++++++++++++++++++
 tb/tb_pack_adapter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pack_adapter.sv
// -----------------------------------------------------------------------------
// pack_adapter
//
// Packs RATIO narrow input beats of WIDTH_DIN bits into one wide output word.
// A word closes either when RATIO beats have been collected or early, when
// a beat arrives with din_last set. Lanes that a partial word does not fill
// are zero and have their keep bit cleared. The closed word is registered
// and appears one clock after its closing beat. The output holds it until
// downstream accepts it.
//
// Parameters
//   WIDTH_DIN  input beat width (1..64)
//   RATIO      beats per output word (2..16)
//   MSB_FIRST  1: first beat in the most significant lane, 0: first beat in lane 0
//
// Ports
//   clk        clock, all logic on the rising edge
//   rstn       synchronous active-low reset
//   din_vld    input beat valid
//   din_rdy    input beat ready (combinational: !dout_vld || dout_rdy)
//   din        input beat data
//   din_last   closes the current word early; sampled only on accept
//   dout_vld   output word valid, held until accepted
//   dout_rdy   downstream ready
//   dout       packed output word
//   dout_keep  per-lane valid mask, bit i covers dout[i*WIDTH_DIN +: WIDTH_DIN]
//   dout_last  word was closed by din_last
//   word_cnt   count of accepted output words (only with PACK_ADAPTER_WCNT_EN)
//
// Optional feature macro: PACK_ADAPTER_WCNT_EN adds the word_cnt port and its
// wrapping 32-bit counter.
// -----------------------------------------------------------------------------
module pack_adapter #(
    parameter int WIDTH_DIN = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       din_vld,
    output logic                       din_rdy,
    input  logic [WIDTH_DIN-1:0]       din,
    input  logic                       din_last,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic [WIDTH_DIN*RATIO-1:0] dout,
    output logic [RATIO-1:0]           dout_keep,
    output logic                       dout_last
`ifdef PACK_ADAPTER_WCNT_EN
    ,
    output logic [31:0]                word_cnt
`endif
);

    localparam int CNT_W  = $clog2(RATIO);
    localparam int WORD_W = WIDTH_DIN * RATIO;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [WORD_W-1:0]   acc_data_r;
    logic [WORD_W-1:0]   acc_data_nxt_s;
    logic [RATIO-1:0]    acc_keep_r;
    logic [RATIO-1:0]    acc_keep_nxt_s;

    logic [WORD_W-1:0]   merged_data_s;
    logic [RATIO-1:0]    merged_keep_s;
    logic [CNT_W-1:0]    lane_s;
    logic                accept_s;
    logic                close_s;

    logic                dout_vld_r;
    logic [WORD_W-1:0]   dout_r;
    logic [RATIO-1:0]    dout_keep_r;
    logic                dout_last_r;

    // Input handshake: a beat is only taken when the output register can
    // absorb a word this cycle, so a closing beat never has to wait.
    always_comb begin
        din_rdy  = !dout_vld_r || dout_rdy;
        accept_s = din_vld && din_rdy;
        close_s  = accept_s && ((cnt_r == CNT_W'(RATIO - 1)) || din_last);
    end

    // Lane selection for the current beat and the accumulator with it merged in.
    always_comb begin
        merged_data_s = acc_data_r;
        merged_keep_s = acc_keep_r;
        if (MSB_FIRST != 0) begin
            lane_s = CNT_W'(RATIO - 1) - cnt_r;
        end else begin
            lane_s = cnt_r;
        end
        for (int i = 0; i < RATIO; i++) begin
            if (lane_s == CNT_W'(i)) begin
                merged_data_s[i*WIDTH_DIN +: WIDTH_DIN] = din;
                merged_keep_s[i]                        = 1'b1;
            end else begin
                merged_data_s[i*WIDTH_DIN +: WIDTH_DIN] = acc_data_r[i*WIDTH_DIN +: WIDTH_DIN];
                merged_keep_s[i]                        = acc_keep_r[i];
            end
        end
    end

    // Next-state logic: accumulate non-closing beats, empty on a closing beat.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        acc_data_nxt_s = acc_data_r;
        acc_keep_nxt_s = acc_keep_r;
        case (state_r)
            ST_EMPTY, ST_FILLING: begin
                if (close_s) begin
                    state_nxt_s    = ST_EMPTY;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                    acc_data_nxt_s = {WORD_W{1'b0}};
                    acc_keep_nxt_s = {RATIO{1'b0}};
                end else if (accept_s) begin
                    state_nxt_s    = ST_FILLING;
                    cnt_nxt_s      = cnt_r + CNT_W'(1);
                    acc_data_nxt_s = merged_data_s;
                    acc_keep_nxt_s = merged_keep_s;
                end else begin
                    state_nxt_s    = state_r;
                end
            end
            default: begin
                state_nxt_s    = ST_EMPTY;
                cnt_nxt_s      = {CNT_W{1'b0}};
                acc_data_nxt_s = {WORD_W{1'b0}};
                acc_keep_nxt_s = {RATIO{1'b0}};
            end
        endcase
    end

    // State, beat counter and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_EMPTY;
            cnt_r      <= {CNT_W{1'b0}};
            acc_data_r <= {WORD_W{1'b0}};
            acc_keep_r <= {RATIO{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            acc_data_r <= acc_data_nxt_s;
            acc_keep_r <= acc_keep_nxt_s;
        end
    end

    // Output word register: loads on a closing beat, otherwise holds its data;
    // valid drops only after an accept with no new word behind it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_vld_r  <= 1'b0;
            dout_r      <= {WORD_W{1'b0}};
            dout_keep_r <= {RATIO{1'b0}};
            dout_last_r <= 1'b0;
        end else if (close_s) begin
            dout_vld_r  <= 1'b1;
            dout_r      <= merged_data_s;
            dout_keep_r <= merged_keep_s;
            dout_last_r <= din_last;
        end else if (dout_vld_r && dout_rdy) begin
            dout_vld_r  <= 1'b0;
        end else begin
            dout_vld_r  <= dout_vld_r;
        end
    end

    assign dout_vld  = dout_vld_r;
    assign dout      = dout_r;
    assign dout_keep = dout_keep_r;
    assign dout_last = dout_last_r;

`ifdef PACK_ADAPTER_WCNT_EN
    logic [31:0] word_cnt_r;

    // Accepted-word counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_cnt_r <= 32'd0;
        end else if (dout_vld_r && dout_rdy) begin
            word_cnt_r <= word_cnt_r + 32'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign word_cnt = word_cnt_r;
`endif

endmodule

// File: tb/tb_pack_adapter.sv
// -----------------------------------------------------------------------------
// tb_pack_adapter
//
// Drives two pack_adapter instances (MSB_FIRST=1 and MSB_FIRST=0) from the
// same stimulus. A beat-list reference model predicts the handshake, the
// packed words for both lane orders and the word count.
// -----------------------------------------------------------------------------
module tb_pack_adapter;

    localparam int W = 8;
    localparam int R = 4;

    logic          clk;
    logic          rstn;
    logic          din_vld;
    logic [W-1:0]  din;
    logic          din_last;
    logic          dout_rdy;

    logic          din_rdy_m,  din_rdy_l;
    logic          dout_vld_m, dout_vld_l;
    logic [W*R-1:0] dout_m,    dout_l;
    logic [R-1:0]  keep_m,     keep_l;
    logic          last_m,     last_l;
`ifdef PACK_ADAPTER_WCNT_EN
    logic [31:0]   wcnt_m,     wcnt_l;
`endif

    pack_adapter #(.WIDTH_DIN(W), .RATIO(R), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rstn(rstn), .din_vld(din_vld), .din_rdy(din_rdy_m),
        .din(din), .din_last(din_last), .dout_vld(dout_vld_m), .dout_rdy(dout_rdy),
        .dout(dout_m), .dout_keep(keep_m), .dout_last(last_m)
`ifdef PACK_ADAPTER_WCNT_EN
        , .word_cnt(wcnt_m)
`endif
    );

    pack_adapter #(.WIDTH_DIN(W), .RATIO(R), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rstn(rstn), .din_vld(din_vld), .din_rdy(din_rdy_l),
        .din(din), .din_last(din_last), .dout_vld(dout_vld_l), .dout_rdy(dout_rdy),
        .dout(dout_l), .dout_keep(keep_l), .dout_last(last_l)
`ifdef PACK_ADAPTER_WCNT_EN
        , .word_cnt(wcnt_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0]   m_beats[$];
    logic           m_vld;
    logic [W*R-1:0] m_word_m, m_word_l;
    logic [R-1:0]   m_keep_m, m_keep_l;
    logic           m_last;
    logic [31:0]    m_wcnt;

    // One clock: apply inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic r_n, input logic v, input logic [W-1:0] d,
                         input logic l, input logic rdy, output logic acc);
        logic exp_rdy;
        int   n;
        rstn = r_n; din_vld = v; din = d; din_last = l; dout_rdy = rdy;
        #1;
        exp_rdy = !m_vld || rdy;
        checks++; if (din_rdy_m !== exp_rdy) begin errors++; $display("FAIL din_rdy: got %b want %b", din_rdy_m, exp_rdy); end
        checks++; if (din_rdy_l !== exp_rdy) begin errors++; $display("FAIL din_rdy_lsb: got %b want %b", din_rdy_l, exp_rdy); end
        checks++; if (dout_vld_m !== m_vld) begin errors++; $display("FAIL dout_vld: got %b want %b", dout_vld_m, m_vld); end
        checks++; if (dout_vld_l !== m_vld) begin errors++; $display("FAIL dout_vld_lsb: got %b want %b", dout_vld_l, m_vld); end
        checks++; if (dout_m !== m_word_m) begin errors++; $display("FAIL dout: got %h want %h", dout_m, m_word_m); end
        checks++; if (dout_l !== m_word_l) begin errors++; $display("FAIL dout_lsb: got %h want %h", dout_l, m_word_l); end
        checks++; if (keep_m !== m_keep_m) begin errors++; $display("FAIL keep: got %h want %h", keep_m, m_keep_m); end
        checks++; if (keep_l !== m_keep_l) begin errors++; $display("FAIL keep_lsb: got %h want %h", keep_l, m_keep_l); end
        checks++; if (last_m !== m_last || last_l !== m_last) begin errors++; $display("FAIL dout_last: got %b/%b want %b", last_m, last_l, m_last); end
`ifdef PACK_ADAPTER_WCNT_EN
        checks++; if (wcnt_m !== m_wcnt || wcnt_l !== m_wcnt) begin errors++; $display("FAIL word_cnt: got %0d/%0d want %0d", wcnt_m, wcnt_l, m_wcnt); end
`endif
        acc = r_n && v && exp_rdy;
        if (!r_n) begin
            m_beats.delete();
            m_vld = 1'b0; m_word_m = '0; m_word_l = '0;
            m_keep_m = '0; m_keep_l = '0; m_last = 1'b0; m_wcnt = 32'd0;
        end else begin
            if (m_vld && rdy) begin
                m_wcnt = m_wcnt + 32'd1;
                m_vld  = 1'b0;
            end
            if (acc) begin
                m_beats.push_back(d);
                if (l || m_beats.size() == R) begin
                    n = m_beats.size();
                    m_word_m = '0; m_word_l = '0; m_keep_m = '0; m_keep_l = '0;
                    for (int k = 0; k < n; k++) begin
                        m_word_m = m_word_m | ((W*R)'(m_beats[k]) << (W * (R - 1 - k)));
                        m_word_l = m_word_l | ((W*R)'(m_beats[k]) << (W * k));
                        m_keep_m[R - 1 - k] = 1'b1;
                        m_keep_l[k]         = 1'b1;
                    end
                    m_last = l;
                    m_vld  = 1'b1;
                    m_beats.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends a list of beats back to back; last flag applies to the final one.
    task automatic send(input logic [W-1:0] b0, input logic [W-1:0] b1,
                        input logic [W-1:0] b2, input logic [W-1:0] b3,
                        input int n, input logic l);
        logic [W-1:0] bl[4];
        logic acc;
        bl[0] = b0; bl[1] = b1; bl[2] = b2; bl[3] = b3;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, bl[i], l && (i == n - 1), 1'b1, acc);
    endtask

    task automatic idle();
        logic acc;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    task automatic test_reset();
        logic acc;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, acc);
        rstn = 1'b1; din_vld = 1'b0; dout_rdy = 1'b0; #1;
        checks++; if (din_rdy_m !== 1'b1) begin errors++; $display("FAIL rdy_after_reset: got %b want 1", din_rdy_m); end
        checks++; if (dout_m !== 32'h0 || keep_m !== 4'h0) begin errors++; $display("FAIL outputs_after_reset: got %h/%h want 0", dout_m, keep_m); end
        idle();
    endtask

    task automatic test_full_word();
        send(8'h11, 8'h22, 8'h33, 8'h44, 4, 1'b0);
        checks++; if (dout_m !== 32'h11223344 || keep_m !== 4'hF || last_m !== 1'b0) begin errors++; $display("FAIL full_msb: got %h/%h/%b want 11223344/f/0", dout_m, keep_m, last_m); end
        checks++; if (dout_l !== 32'h44332211 || keep_l !== 4'hF) begin errors++; $display("FAIL full_lsb: got %h/%h want 44332211/f", dout_l, keep_l); end
        idle();
    endtask

    task automatic test_partial();
        send(8'hAA, 8'hBB, 8'h00, 8'h00, 2, 1'b1);
        checks++; if (dout_m !== 32'hAABB0000 || keep_m !== 4'hC || last_m !== 1'b1) begin errors++; $display("FAIL partial: got %h/%h/%b want aabb0000/c/1", dout_m, keep_m, last_m); end
        checks++; if (dout_l !== 32'h0000BBAA || keep_l !== 4'h3) begin errors++; $display("FAIL partial_lsb: got %h/%h want 0000bbaa/3", dout_l, keep_l); end
        send(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b0);
        checks++; if (dout_m !== 32'h01020304 || keep_m !== 4'hF) begin errors++; $display("FAIL after_partial: got %h/%h want 01020304/f", dout_m, keep_m); end
        send(8'h5A, 8'h00, 8'h00, 8'h00, 1, 1'b1);
        checks++; if (dout_m !== 32'h5A000000 || keep_m !== 4'h8 || last_m !== 1'b1) begin errors++; $display("FAIL first_last: got %h/%h/%b want 5a000000/8/1", dout_m, keep_m, last_m); end
        send(8'hC1, 8'hC2, 8'hC3, 8'hC4, 4, 1'b1);
        checks++; if (keep_m !== 4'hF || last_m !== 1'b1) begin errors++; $display("FAIL full_with_last: got %h/%b want f/1", keep_m, last_m); end
        idle();
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        logic acc;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b1, sent < 12, 8'(8'h60 + sent), 1'b0, (c < 4) || (c >= 12), acc);
            if (acc) sent++;
        end
        checks++; if (sent !== 12) begin errors++; $display("FAIL bp_beats: got %0d want 12", sent); end
        idle();
    endtask

    task automatic test_reset_mid();
        logic acc;
        send(8'hE1, 8'hE2, 8'h00, 8'h00, 2, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);
        send(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b0);
        checks++; if (dout_m !== 32'h01020304 || keep_m !== 4'hF) begin errors++; $display("FAIL reset_mid: got %h/%h want 01020304/f", dout_m, keep_m); end
        idle();
    endtask

    task automatic test_back_to_back();
        int   pulses = 0;
        logic acc;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, acc);
            if (dout_vld_m === 1'b1) pulses++;
        end
        checks++; if (pulses !== 16) begin errors++; $display("FAIL throughput: got %0d want 16", pulses); end
        idle();
    endtask

    task automatic test_random();
        logic [W-1:0] beat;
        logic         bl;
        logic         acc;
        beat = 8'($urandom);
        bl   = ($urandom_range(0, 5) == 0);
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, beat, bl,
                  $urandom_range(0, 2) != 0, acc);
            if (acc) begin
                beat = 8'($urandom);
                bl   = ($urandom_range(0, 5) == 0);
            end
        end
        idle();
    endtask

    initial begin
        rstn = 1'b0; din_vld = 1'b0; din = '0; din_last = 1'b0; dout_rdy = 1'b0;
        m_vld = 1'b0; m_word_m = '0; m_word_l = '0; m_keep_m = '0; m_keep_l = '0;
        m_last = 1'b0; m_wcnt = 32'd0;
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
